chkrpl: RTL and testbench



---
 rtl/chkrpl_pkg.sv | 19 +
 rtl/chkrpl_stage.sv | 58 +++++
 rtl/chkrpl.sv | 61 ++++++
 tb/tb_chkrpl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/chkrpl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chkrpl_pkg
// Brief    : Default sizing and reset constant for the chkrpl scan pipeline.
// Revision : 1.0
// ============================================================================
package chkrpl_pkg;

  localparam int          CHKRPL_WIDTH   = 4;
  localparam int          CHKRPL_STAGES  = 3;
  localparam logic [3:0]  CHKRPL_RST_VAL = 4'hA;

  // Total number of flops on the scan chain for a given geometry.
  function automatic int chkrpl_chain_len(input int width, input int stages);
    return width * stages;
  endfunction

endpackage : chkrpl_pkg
`default_nettype wire

// File: rtl/chkrpl_stage.sv
`default_nettype none
// ============================================================================
// Module   : chkrpl_stage
// Brief    : One WIDTH-bit pipeline register with mux-D scan (CHKRPL_SCAN_EN).
// Revision : 1.0
// ============================================================================
module chkrpl_stage
  import chkrpl_pkg::*;
#(
  parameter int               WIDTH   = CHKRPL_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CHKRPL_RST_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_shift,
  input  logic             scan_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             scan_out
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

`ifdef CHKRPL_SCAN_EN
  logic [WIDTH-1:0] w_shifted;

  // Chain runs bit0 -> bit WIDTH-1 within the stage.
  always_comb begin
    w_shifted    = '0;
    w_shifted[0] = scan_in;
    for (int i = 1; i < WIDTH; i++) begin
      w_shifted[i] = r_q[i-1];
    end
  end

  assign w_next   = scan_shift ? w_shifted : d;
  assign scan_out = r_q[WIDTH-1];
`else
  logic w_unused;

  assign w_unused = scan_shift ^ scan_in;
  assign w_next   = d;
  assign scan_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule : chkrpl_stage
`default_nettype wire

// File: rtl/chkrpl.sv
`default_nettype none
// ============================================================================
// Module   : chkrpl
// Brief    : Fixed-latency scannable register pipeline; scan built if CHKRPL_SCAN_EN.
// Revision : 1.0
// ============================================================================
module chkrpl
  import chkrpl_pkg::*;
#(
  parameter int               WIDTH   = CHKRPL_WIDTH,
  parameter int               STAGES  = CHKRPL_STAGES,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CHKRPL_RST_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  input  logic             test_mode,
  input  logic             scan_en,
  input  logic             scan_in0,
  output logic             scan_out0
);

  logic [STAGES:0][WIDTH-1:0] w_data;
  logic [STAGES:0]            w_scan;
  logic                       w_shift_en;

`ifdef CHKRPL_SCAN_EN
  // scan_en alone never disturbs functional capture.
  assign w_shift_en = test_mode & scan_en;
  assign w_scan[0]  = scan_in0;
`else
  logic w_unused;

  assign w_unused   = test_mode ^ scan_en ^ scan_in0;
  assign w_shift_en = 1'b0;
  assign w_scan[0]  = 1'b0;
`endif

  assign w_data[0] = d_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chkrpl_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .scan_shift (w_shift_en),
      .scan_in    (w_scan[k]),
      .d          (w_data[k]),
      .q          (w_data[k+1]),
      .scan_out   (w_scan[k+1])
    );
  end

  assign d_out     = w_data[STAGES];
  assign scan_out0 = w_scan[STAGES];

endmodule : chkrpl
`default_nettype wire

// File: tb/tb_chkrpl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chkrpl
// Brief    : Directed self-checking bench for the chkrpl scan pipeline.
// Revision : 1.0
// ============================================================================
module tb_chkrpl;

`ifdef CHKRPL_SCAN_EN
  localparam bit C_SCAN_BUILD = 1'b1;
`else
  localparam bit C_SCAN_BUILD = 1'b0;
`endif

  logic       clk_tb;
  logic       reset;
  logic [3:0] d_in;
  logic [3:0] d_out;
  logic       test_mode;
  logic       scan_en;
  logic       scan_in0;
  logic       scan_out0;

  int n_checks;
  int n_fail;

  chkrpl u_dut (
    .clk       (clk_tb),
    .reset     (reset),
    .d_in      (d_in),
    .d_out     (d_out),
    .test_mode (test_mode),
    .scan_en   (scan_en),
    .scan_in0  (scan_in0),
    .scan_out0 (scan_out0)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge.
  task automatic cycle();
    @(posedge clk_tb);
    #5;
  endtask

  initial begin
    logic [11:0] pat;
    logic [3:0]  words [300];

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    d_in      = 4'h5;
    test_mode = 1'b0;
    scan_en   = 1'b0;
    scan_in0  = 1'b0;

    cycle();
    cycle();
    check_eq("reset_dout", 32'(d_out), 32'hA);
    check_eq("reset_scan_out", 32'(scan_out0), C_SCAN_BUILD ? 32'd1 : 32'd0);

    // Latency after release.
    reset = 1'b1;
    d_in  = 4'h3;
    cycle();
    check_eq("lat_edge1", 32'(d_out), 32'hA);
    d_in = 4'hC;
    cycle();
    check_eq("lat_edge2", 32'(d_out), 32'hA);
    d_in = 4'h0;
    cycle();
    check_eq("lat_edge3", 32'(d_out), 32'h3);
    cycle();
    check_eq("lat_edge4", 32'(d_out), 32'hC);

    // Random streaming.
    for (int i = 0; i < 300; i++) begin
      words[i] = 4'($urandom_range(0, 15));
      d_in     = words[i];
      cycle();
      if (i >= 2) check_eq("stream", 32'(d_out), 32'(words[i-2]));
    end

    // scan_en without test_mode must behave functionally.
    test_mode = 1'b0;
    scan_en   = 1'b1;
    scan_in0  = 1'b1;
    d_in      = 4'h7;
    cycle();
    cycle();
    cycle();
    check_eq("gated_dout", 32'(d_out), 32'h7);
    check_eq("gated_scan_out", 32'(scan_out0), 32'd0);

    // Scan capture cycle: test_mode without scan_en.
    test_mode = 1'b1;
    scan_en   = 1'b0;
    d_in      = 4'hE;
    cycle();
    cycle();
    cycle();
    check_eq("capture_dout", 32'(d_out), 32'hE);

    test_mode = 1'b1;
    scan_en   = 1'b1;
    if (C_SCAN_BUILD) begin
      pat = 12'hA5C;
      for (int e = 0; e < 12; e++) begin
        scan_in0 = pat[11-e];
        d_in     = 4'($urandom_range(0, 15));
        cycle();
      end
      check_eq("shift_in_dout", 32'(d_out), 32'hA);
      check_eq("shift_out_11", 32'(scan_out0), 32'(pat[11]));
      scan_in0 = 1'b0;
      for (int e = 0; e < 12; e++) begin
        d_in = 4'($urandom_range(0, 15));
        cycle();
        check_eq("shift_out", 32'(scan_out0), (e < 11) ? 32'(pat[10-e]) : 32'd0);
      end
      check_eq("shift_flush_dout", 32'(d_out), 32'h0);
    end else begin
      scan_in0 = 1'b1;
      d_in = 4'h9;
      cycle();
      d_in = 4'hB;
      cycle();
      d_in = 4'h6;
      cycle();
      check_eq("noscan_dout0", 32'(d_out), 32'h9);
      cycle();
      check_eq("noscan_dout1", 32'(d_out), 32'hB);
      check_eq("noscan_scan_out", 32'(scan_out0), 32'd0);
    end

    // Mid-stream reset.
    test_mode = 1'b0;
    scan_en   = 1'b0;
    scan_in0  = 1'b0;
    d_in = 4'h1;
    cycle();
    d_in = 4'h2;
    cycle();
    d_in = 4'h3;
    cycle();
    check_eq("mid_pre", 32'(d_out), 32'h1);
    reset = 1'b0;
    d_in  = 4'h4;
    cycle();
    check_eq("mid_reset", 32'(d_out), 32'hA);
    reset = 1'b1;
    d_in  = 4'h6;
    cycle();
    check_eq("mid_rel1", 32'(d_out), 32'hA);
    d_in = 4'h8;
    cycle();
    check_eq("mid_rel2", 32'(d_out), 32'hA);
    cycle();
    check_eq("mid_data0", 32'(d_out), 32'h6);
    cycle();
    check_eq("mid_data1", 32'(d_out), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_chkrpl
`default_nettype wire
